// File: rtl/link_pkg.sv
// Shared opcodes, order record layout and FSM encoding for the link order arbiter.
// Latency: none; declarations only.
// Backpressure: none; declarations only.
package link_pkg;

    // Order opcodes as carried on req_type / order_type.
    localparam logic [1:0] APPE = 2'b00;
    localparam logic [1:0] DELE = 2'b01;
    localparam logic [1:0] CHAG = 2'b10;
    localparam logic [1:0] READ = 2'b11;

    // Field widths of the default link_top build.
    localparam int LINK_ADDR_W  = 16;
    localparam int LINK_DATA_W  = 16;
    localparam int LINK_TABLE_W = 8;

    // One order as presented to link_top, at the default field widths.
    typedef struct packed {
        logic [1:0]              op;
        logic [LINK_TABLE_W-1:0] tbl;
        logic [LINK_ADDR_W-1:0]  node;
        logic [LINK_DATA_W-1:0]  data;
    } order_t;

    // Arbiter FSM: IDLE picks a winner, ISSUE holds the order until link_top takes it.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/link_tag_fifo.sv
// Synchronous FIFO of requester tags for READs still waiting on their data.
// Latency: a pushed entry is visible at the head on the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty; caller watches full/empty.
//
// Ports: clk, rst (async, active high), push_vld/push_dat write side,
//        pop_vld read side, head_dat oldest entry, full/empty status.
module link_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra wrap bit on each pointer separates full from empty.
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok  = push_vld && !full;
    assign pop_ok   = pop_vld && !empty;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head_dat = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[PTR_W-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/link_order_arbiter.sv
// Round-robin arbiter sharing link_top's single order port; READ data steered back in issue order.
// Latency: request captured on edge n, order_valid from n+1; at least 2 cycles per order.
// Backpressure: order_busy holds ISSUE (all req_busy high); dout_busy follows rsp_busy of the oldest READ.
//
// Ports: clk, rst (async, active high);
//        req_valid/req_busy + packed req_type/req_table/req_node/req_data per requester;
//        order_valid/order_busy + order_type/order_table/order_node/order_data to link_top;
//        dout_valid/dout_busy/dout_data read return from link_top;
//        rsp_valid (one-hot)/rsp_busy/rsp_data to requesters; err_orphan sticky.
// Build option: LINK_ARB_PRIO0_EN gives requester 0 strict priority over the round robin.
module link_order_arbiter
    import link_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int TABLE_WIDTH = 8,
    parameter int RD_DEPTH    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_busy,
    input  logic [2*NUM_REQ-1:0]           req_type,
    input  logic [TABLE_WIDTH*NUM_REQ-1:0] req_table,
    input  logic [ADDR_WIDTH*NUM_REQ-1:0]  req_node,
    input  logic [DATA_WIDTH*NUM_REQ-1:0]  req_data,
    output logic                           order_valid,
    input  logic                           order_busy,
    output logic [1:0]                     order_type,
    output logic [TABLE_WIDTH-1:0]         order_table,
    output logic [ADDR_WIDTH-1:0]          order_node,
    output logic [DATA_WIDTH-1:0]          order_data,
    input  logic                           dout_valid,
    output logic                           dout_busy,
    input  logic [DATA_WIDTH-1:0]          dout_data,
    output logic [NUM_REQ-1:0]             rsp_valid,
    input  logic [NUM_REQ-1:0]             rsp_busy,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic                           err_orphan
);
    localparam int TAG_W = $clog2(NUM_REQ);

    // Same layout as link_pkg::order_t, at this instance's widths.
    typedef struct packed {
        logic [1:0]             op;
        logic [TABLE_WIDTH-1:0] tbl;
        logic [ADDR_WIDTH-1:0]  node;
        logic [DATA_WIDTH-1:0]  data;
    } ord_t;

    arb_state_t         state;
    arb_state_t         state_nxt;
    ord_t               ord;
    logic [TAG_W-1:0]   rr;
    logic               capture;

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] rr_elig;
    logic               rr_vld;
    logic [TAG_W-1:0]   rr_idx;
    logic               grant_vld;
    logic [TAG_W-1:0]   grant_idx;
    logic               rr_adv;

    logic               tag_push;
    logic               tag_pop;
    logic [TAG_W-1:0]   tag_head;
    logic               tag_full;
    logic               tag_empty;

    // A READ is only eligible with a free tag slot. The full flag is taken
    // before any same-cycle pop so the decision never depends on dout_valid.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_valid[i] && !((req_type[2*i +: 2] == READ) && tag_full);
        end
    end

    // First eligible requester at or after rr, wrapping.
    always_comb begin
        int idx;
        idx    = 0;
        rr_vld = 1'b0;
        rr_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!rr_vld && rr_elig[idx]) begin
                rr_vld = 1'b1;
                rr_idx = idx[TAG_W-1:0];
            end
        end
    end

`ifdef LINK_ARB_PRIO0_EN
    // Requester 0 bypasses the rotation and leaves rr untouched when it wins.
    assign rr_elig   = {elig[NUM_REQ-1:1], 1'b0};
    assign grant_vld = elig[0] || rr_vld;
    assign grant_idx = elig[0] ? '0 : rr_idx;
    assign rr_adv    = !elig[0];
`else
    assign rr_elig   = elig;
    assign grant_vld = rr_vld;
    assign grant_idx = rr_idx;
    assign rr_adv    = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        capture     = 1'b0;
        req_busy    = '1;
        order_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                // rst gate keeps every requester stalled while reset is held.
                if (grant_vld && !rst) begin
                    capture             = 1'b1;
                    req_busy[grant_idx] = 1'b0;
                    state_nxt           = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                order_valid = 1'b1;
                if (!order_busy) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ord <= '0;
            rr  <= '0;
        end else if (capture) begin
            ord.op   <= req_type[2*grant_idx +: 2];
            ord.tbl  <= req_table[TABLE_WIDTH*grant_idx +: TABLE_WIDTH];
            ord.node <= req_node[ADDR_WIDTH*grant_idx +: ADDR_WIDTH];
            ord.data <= req_data[DATA_WIDTH*grant_idx +: DATA_WIDTH];
            if (rr_adv) begin
                rr <= (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);
            end
        end
    end

    assign order_type  = ord.op;
    assign order_table = ord.tbl;
    assign order_node  = ord.node;
    assign order_data  = ord.data;

    assign tag_push = capture && (req_type[2*grant_idx +: 2] == READ);

    link_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (RD_DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (tag_push),
        .push_dat (grant_idx),
        .pop_vld  (tag_pop),
        .head_dat (tag_head),
        .full     (tag_full),
        .empty    (tag_empty)
    );

    // Read return goes to the oldest outstanding READ. With nothing
    // outstanding the data is accepted and dropped so link_top never stalls.
    always_comb begin
        rsp_valid = '0;
        dout_busy = 1'b0;
        tag_pop   = 1'b0;
        if (!tag_empty) begin
            rsp_valid[tag_head] = dout_valid;
            dout_busy           = rsp_busy[tag_head];
            tag_pop             = dout_valid && !rsp_busy[tag_head];
        end
    end

    assign rsp_data = dout_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_orphan <= 1'b0;
        end else if (dout_valid && tag_empty) begin
            err_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_link_order_arbiter.sv
// Bench for link_order_arbiter: directed scenarios then randomized traffic against a reference model.
// Latency: expectations sampled 1 time unit after each input change, model advanced once per clock.
// Backpressure: bench plays both requesters and link_top, driving order_busy/rsp_busy/dout_valid.
module tb_link_order_arbiter;
    import link_pkg::*;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TW = 8;
    localparam int RD = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_busy;
    logic [2*N-1:0]  req_type;
    logic [TW*N-1:0] req_table;
    logic [AW*N-1:0] req_node;
    logic [DW*N-1:0] req_data;
    logic            order_valid;
    logic            order_busy;
    logic [1:0]      order_type;
    logic [TW-1:0]   order_table;
    logic [AW-1:0]   order_node;
    logic [DW-1:0]   order_data;
    logic            dout_valid;
    logic            dout_busy;
    logic [DW-1:0]   dout_data;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_busy;
    logic [DW-1:0]   rsp_data;
    logic            err_orphan;

    link_order_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TABLE_WIDTH(TW), .RD_DEPTH(RD)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_busy(req_busy), .req_type(req_type),
        .req_table(req_table), .req_node(req_node), .req_data(req_data),
        .order_valid(order_valid), .order_busy(order_busy), .order_type(order_type),
        .order_table(order_table), .order_node(order_node), .order_data(order_data),
        .dout_valid(dout_valid), .dout_busy(dout_busy), .dout_data(dout_data),
        .rsp_valid(rsp_valid), .rsp_busy(rsp_busy), .rsp_data(rsp_data),
        .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: issue slot, latched order, rotation pointer, outstanding READ owners.
    bit     m_issuing;
    order_t m_ord;
    int     m_rr;
    int     m_tags[$];
    bit     m_err;

    // DUT outputs as sampled in the latest step.
    logic [N-1:0]  s_busy, s_rsp;
    logic          s_ov, s_db, s_err;
    logic [1:0]    s_otype;
    logic [TW-1:0] s_otbl;
    logic [AW-1:0] s_node;
    logic [DW-1:0] s_odata, s_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_issuing = 1'b0;
        m_ord     = '0;
        m_rr      = 0;
        m_tags.delete();
        m_err     = 1'b0;
    endfunction

    function automatic int model_pick();
        bit elig[N];
        for (int i = 0; i < N; i++) begin
            elig[i] = req_valid[i] && !(req_type[2*i +: 2] == READ && m_tags.size() >= RD);
        end
`ifdef LINK_ARB_PRIO0_EN
        if (elig[0]) return 0;
        elig[0] = 1'b0;
`endif
        for (int k = 0; k < N; k++) begin
            if (elig[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    function automatic int busy_to_idx(input logic [N-1:0] b);
        int r = -1;
        for (int i = 0; i < N; i++) begin
            if (!b[i]) r = (r == -1) ? i : -2;
        end
        return r;
    endfunction

    task automatic set_req(input int i, input logic v, input logic [1:0] t,
                           input logic [TW-1:0] tb, input logic [AW-1:0] nd, input logic [DW-1:0] dt);
        req_valid[i]         = v;
        req_type[2*i +: 2]   = t;
        req_table[TW*i +: TW] = tb;
        req_node[AW*i +: AW] = nd;
        req_data[DW*i +: DW] = dt;
    endtask

    // One clock: sample and compare against the model, advance the model,
    // return on the next falling edge. The winning requester drops its valid.
    task automatic step();
        int g;
        int h;
        logic [N-1:0] e_busy;
        logic [N-1:0] e_rsp;
        logic         e_db;
        #1;
        s_busy = req_busy;   s_ov = order_valid; s_otype = order_type; s_otbl = order_table;
        s_node = order_node; s_odata = order_data; s_rsp = rsp_valid; s_db = dout_busy;
        s_err  = err_orphan; s_rdata = rsp_data;
        g = -1;
        h = -1;
        if (rst) model_reset();
        else if (!m_issuing) g = model_pick();
        e_busy = '1;
        if (g >= 0) e_busy[g] = 1'b0;
        e_rsp = '0;
        e_db  = 1'b0;
        if (m_tags.size() > 0) begin
            h        = m_tags[0];
            e_rsp[h] = dout_valid;
            e_db     = rsp_busy[h];
        end
        check("req_busy",    32'(s_busy), 32'(e_busy));
        check("order_valid", 32'(s_ov),   32'(m_issuing));
        check("rsp_valid",   32'(s_rsp),  32'(e_rsp));
        check("dout_busy",   32'(s_db),   32'(e_db));
        check("rsp_data",    32'(s_rdata), 32'(dout_data));
        check("err_orphan",  32'(s_err),  32'(m_err));
        if (m_issuing || rst) begin
            check("order_type",  32'(s_otype), 32'(m_ord.op));
            check("order_table", 32'(s_otbl),  32'(m_ord.tbl));
            check("order_node",  32'(s_node),  32'(m_ord.node));
            check("order_data",  32'(s_odata), 32'(m_ord.data));
        end
        if (!rst) begin
            if (h >= 0) begin
                if (dout_valid && !rsp_busy[h]) void'(m_tags.pop_front());
            end else if (dout_valid) begin
                m_err = 1'b1;
            end
            if (m_issuing && !order_busy) m_issuing = 1'b0;
            if (g >= 0) begin
                m_issuing  = 1'b1;
                m_ord.op   = req_type[2*g +: 2];
                m_ord.tbl  = req_table[TW*g +: TW];
                m_ord.node = req_node[AW*g +: AW];
                m_ord.data = req_data[DW*g +: DW];
                if (m_ord.op == READ) m_tags.push_back(g);
`ifdef LINK_ARB_PRIO0_EN
                if (g != 0) m_rr = (g + 1) % N;
`else
                m_rr = (g + 1) % N;
`endif
            end
        end
        @(negedge clk);
        if (g >= 0) req_valid[g] = 1'b0;
    endtask

    initial begin
        int prev;
        int g;
        rst = 1'b1;
        req_valid = '0; req_type = '0; req_table = '0; req_node = '0; req_data = '0;
        order_busy = 1'b0; dout_valid = 1'b0; dout_data = '0; rsp_busy = '0;
        model_reset();

        // Reset state.
        @(negedge clk);
        set_req(0, 1'b1, APPE, 8'h1, 16'h1, 16'h1);
        step();
        check("rst_req_busy", 32'(s_busy), 'hF);
        check("rst_order_valid", 32'(s_ov), 0);
        check("rst_order_node", 32'(s_node), 0);
        check("rst_dout_busy", 32'(s_db), 0);
        rst = 1'b0;
        req_valid = '0;

        // Three APPEs at once: issued 0,1,2 on cycles 1,3,5.
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, APPE, TW'(i), AW'(10 + i), DW'(i));
        for (int c = 0; c < 6; c++) begin
            step();
            check("t1_order_valid", 32'(s_ov), c % 2);
            if (c % 2 == 1) check("t1_order_node", 32'(s_node), 10 + c / 2);
        end
        // rr now 3: all four requesting picks 3 (requester 0 under priority build).
        for (int i = 0; i < N; i++) set_req(i, 1'b1, APPE, 8'h0, 16'h0, 16'h0);
        step();
`ifdef LINK_ARB_PRIO0_EN
        check("t1_rr_next", 32'(s_busy), 'hE);
`else
        check("t1_rr_next", 32'(s_busy), 'h7);
`endif
        req_valid = '0;
        step();

        // READ from requester 2, link_top answers 113.
        set_req(2, 1'b1, READ, 8'd3, 16'd3, 16'd0);
        step();
        check("t2_grant", 32'(s_busy), 'hB);
        step();
        check("t2_order_type", 32'(s_otype), 3);
        check("t2_order_node", 32'(s_node), 3);
        check("t2_order_table", 32'(s_otbl), 3);
        dout_valid = 1'b1; dout_data = 16'd113;
        step();
        check("t2_rsp_valid", 32'(s_rsp), 'h4);
        check("t2_rsp_data", 32'(s_rdata), 113);
        dout_valid = 1'b0; rsp_busy = '1;
        step();
        check("t2_fifo_empty", 32'(s_db), 0);
        rsp_busy = '0;

        // order_busy held 5 cycles in ISSUE.
        set_req(1, 1'b1, CHAG, 8'd5, 16'h55, 16'hABCD);
        order_busy = 1'b1;
        step();
        set_req(0, 1'b1, APPE, 8'd0, 16'h77, 16'h0);
        for (int c = 0; c < 5; c++) begin
            step();
            check("t3_hold_valid", 32'(s_ov), 1);
            check("t3_hold_node", 32'(s_node), 'h55);
            check("t3_hold_data", 32'(s_odata), 'hABCD);
            check("t3_hold_busy", 32'(s_busy), 'hF);
        end
        order_busy = 1'b0;
        step();
        check("t3_release_node", 32'(s_node), 'h55);
        step();
        check("t3_after_valid", 32'(s_ov), 0);
        check("t3_next_grant", 32'(s_busy), 'hE);
        step();
        check("t3_next_node", 32'(s_node), 'h77);

        // Four unanswered READs from requester 1 fill the tag FIFO.
        for (int k = 0; k < RD; k++) begin
            set_req(1, 1'b1, READ, 8'd1, AW'(k), 16'd0);
            step();
            check("t4_read_grant", 32'(s_busy), 'hD);
            step();
        end
        set_req(1, 1'b1, READ, 8'd1, 16'd9, 16'd0);
        set_req(3, 1'b1, CHAG, 8'd2, 16'h33, 16'd0);
        step();
        check("t4_full_skip", 32'(s_busy), 'h7);
        step();
        step();
        check("t4_blocked", 32'(s_busy), 'hF);
        dout_valid = 1'b1; dout_data = 16'd1;
        step();
        check("t4_blocked_pop", 32'(s_busy), 'hF);
        check("t4_pop_rsp", 32'(s_rsp), 'h2);
        dout_valid = 1'b0;
        step();
        check("t4_unblocked", 32'(s_busy), 'hD);
        step();

        // Response held by rsp_busy for 3 cycles, then delivered once.
        dout_valid = 1'b1; dout_data = 16'hBEEF; rsp_busy = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            step();
            check("t5_dout_busy", 32'(s_db), 1);
            check("t5_rsp_held", 32'(s_rsp), 'h2);
        end
        rsp_busy = '0;
        step();
        check("t5_dout_free", 32'(s_db), 0);
        dout_valid = 1'b0;
        step();
        check("t5_no_repeat", 32'(s_rsp), 0);
        dout_valid = 1'b1;
        for (int c = 0; c < RD - 1; c++) begin
            step();
            check("t5_drain", 32'(s_rsp), 'h2);
        end
        step();
        check("t5_orphan_rsp", 32'(s_rsp), 0);
        check("t5_orphan_busy", 32'(s_db), 0);
        check("t5_err_before", 32'(s_err), 0);
        dout_valid = 1'b0;
        step();
        check("t5_err_set", 32'(s_err), 1);

        // Requesters 0 and 1 continuously valid.
        prev = -1;
        for (int k = 0; k < 6; k++) begin
            set_req(0, 1'b1, APPE, 8'd0, AW'(k), 16'd0);
            set_req(1, 1'b1, APPE, 8'd0, AW'(k), 16'd0);
            step();
            g = busy_to_idx(s_busy);
`ifdef LINK_ARB_PRIO0_EN
            check("t6_prio0", g, 0);
`else
            check("t6_grant_range", 32'(g == 0 || g == 1), 1);
            if (k > 0) check("t6_alternate", g, 1 - prev);
`endif
            prev = g;
            step();
        end
        req_valid = '0;

        // Reset mid-ISSUE with an outstanding READ.
        set_req(2, 1'b1, READ, 8'd1, 16'd1, 16'd0);
        order_busy = 1'b1;
        step();
        step();
        check("t7_in_issue", 32'(s_ov), 1);
        rst = 1'b1;
        step();
        check("t7_rst_valid", 32'(s_ov), 0);
        check("t7_rst_busy", 32'(s_busy), 'hF);
        rst = 1'b0; order_busy = 1'b0;
        step();
        check("t7_err_cleared", 32'(s_err), 0);
        dout_valid = 1'b1;
        step();
        check("t7_tag_dropped", 32'(s_rsp), 0);
        dout_valid = 1'b0;
        step();
        check("t7_err_orphan", 32'(s_err), 1);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            rst        = ($urandom_range(0, 199) == 0);
            req_valid  = N'($urandom);
            req_type   = (2*N)'($urandom);
            req_table  = (TW*N)'($urandom);
            req_node   = {$urandom, $urandom};
            req_data   = {$urandom, $urandom};
            order_busy = ($urandom_range(0, 2) == 0);
            dout_valid = ($urandom_range(0, 2) == 0);
            dout_data  = DW'($urandom);
            rsp_busy   = N'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
